// File: rtl/alu_pkg.sv
// Shared ALU opcodes, FSM state encoding and opcode helpers for the ALU arbiter.
package alu_pkg;

  localparam logic [3:0] ALU_ADD     = 4'd0;
  localparam logic [3:0] ALU_SUB     = 4'd1;
  localparam logic [3:0] ALU_XOR     = 4'd2;
  localparam logic [3:0] ALU_OR      = 4'd3;
  localparam logic [3:0] ALU_AND     = 4'd4;
  localparam logic [3:0] ALU_SLL     = 4'd5;
  localparam logic [3:0] ALU_SRL     = 4'd6;
  localparam logic [3:0] ALU_SRA     = 4'd7;
  localparam logic [3:0] ALU_SLT     = 4'd8;
  localparam logic [3:0] ALU_SLTU    = 4'd9;
  localparam logic [3:0] ALU_OP_LAST = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // Shifts only look at the low five bits of operand B.
  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  // Opcodes above ALU_OP_LAST have no ALU meaning and return an error response.
  function automatic logic is_bad_op(input logic [3:0] op);
    return op > ALU_OP_LAST;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared combinational 32-bit ALU; opcodes outside 0..9 yield zero.
import alu_pkg::*;

module ALU (
  input  logic [3:0]  op,
  input  logic [31:0] in_1,
  input  logic [31:0] in_2,
  output logic [31:0] out
);

  // Pure combinational operation select, modulo 2^32.
  always_comb begin
    out = '0;
    case (op)
      ALU_ADD:  out = in_1 + in_2;
      ALU_SUB:  out = in_1 - in_2;
      ALU_XOR:  out = in_1 ^ in_2;
      ALU_OR:   out = in_1 | in_2;
      ALU_AND:  out = in_1 & in_2;
      ALU_SLL:  out = in_1 << in_2[4:0];
      ALU_SRL:  out = in_1 >> in_2[4:0];
      ALU_SRA:  out = $signed(in_1) >>> in_2[4:0];
      ALU_SLT:  out = {31'd0, $signed(in_1) < $signed(in_2)};
      ALU_SLTU: out = {31'd0, in_1 < in_2};
      default:  out = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters.
// One op in flight: IDLE (accept) -> EXEC (compute) -> RESP (hold until taken).
import alu_pkg::*;

module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [4*NUM_REQ-1:0]    req_op,
  input  logic [32*NUM_REQ-1:0]   req_in_1,
  input  logic [32*NUM_REQ-1:0]   req_in_2,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_data,
  output logic                    rsp_err,
  input  logic                    rsp_ready,
  output logic                    busy
);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0]      op_q, op_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;

  logic [ID_W-1:0] grant;
  logic [31:0]     alu_b;
  logic [31:0]     alu_out;

  // First valid requester at or after ptr, wrapping; scanning backwards lets
  // the closest-to-ptr hit overwrite farther ones without an early exit.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [ID_W-1:0]    ptr);
    int idx;
    rr_pick = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (v[idx]) rr_pick = ID_W'(idx);
    end
  endfunction

  assign grant = rr_pick(req_valid, rr_ptr_q);

  // Shift amount masking happens here so the ALU itself stays unmodified.
  assign alu_b = is_shift(op_q) ? {27'd0, b_q[4:0]} : b_q;

  ALU u_alu (
    .op   (op_q),
    .in_1 (a_q),
    .in_2 (alu_b),
    .out  (alu_out)
  );

  // Next-state, grant and register-load logic.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = '0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          req_ready[grant] = 1'b1;
          op_d     = req_op[4*int'(grant) +: 4];
          a_d      = req_in_1[32*int'(grant) +: 32];
          b_d      = req_in_2[32*int'(grant) +: 32];
          id_d     = grant;
          rr_ptr_d = ID_W'((int'(grant) + 1) % NUM_REQ);
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_err_d   = is_bad_op(op_q);
        rsp_data_d  = is_bad_op(op_q) ? 32'd0 : alu_out;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        // rsp_* are simply held; the bubble comes from going to IDLE, not EXEC.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
